// File: rtl/cq_viola_psw_in.sv
// Push-switch / DIP-switch input port on the cq_viola s1 slave bus.
// Pins are synchronised, debounced per bit on a slow sample tick, and edges
// of the debounced level are latched into a sticky capture register that
// drives a masked level interrupt.

// One pin's debounce: a short history of tick samples. The debounced level
// only moves once the whole history agrees.
module cq_viola_psw_in_lane #(
  parameter int   DEB_SAMPLES = 4,
  parameter logic INIT_BIT    = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic s2_bit,
  output logic deb
);

  logic [DEB_SAMPLES-1:0] hist;

  // shift in the synchronised pin once per sample tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  hist <= {DEB_SAMPLES{INIT_BIT}};
    else if (tick) hist <= {hist[DEB_SAMPLES-2:0], s2_bit};
  end

  // follow the history only when it is unanimous, otherwise hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     deb <= INIT_BIT;
    else if (&hist)   deb <= 1'b1;
    else if (~|hist)  deb <= 1'b0;
  end

endmodule

module cq_viola_psw_in #(
  parameter int WIDTH       = 8,
  parameter int SAMPLE_DIV  = 50000,
  parameter int DEB_SAMPLES = 4,
  parameter int EDGE_TYPE   = 1,
  parameter int INIT_LEVEL  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int   CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic INIT  = (INIT_LEVEL != 0);

  logic [WIDTH-1:0] s1, s2, deb, deb_d;
  logic [WIDTH-1:0] irqmask, edgecapture;
  logic [WIDTH-1:0] rise, fall, edge_hit, clr;
  logic [CNT_W-1:0] cnt;
  logic             tick, wr;

  assign wr   = chipselect & ~write_n;
  assign tick = (cnt == CNT_W'(SAMPLE_DIV - 1));

  // only the low WIDTH bits of the bus carry register data
  generate
    if (WIDTH < 32) begin : g_wd_unused
      logic wd_unused;
      assign wd_unused = ^writedata[31:WIDTH];
    end
  endgenerate

  // two-flop synchroniser for the asynchronous pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= {WIDTH{INIT}};
      s2 <= {WIDTH{INIT}};
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  // free-running sample prescaler
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  generate
    for (genvar b = 0; b < WIDTH; b++) begin : g_lane
      cq_viola_psw_in_lane #(
        .DEB_SAMPLES (DEB_SAMPLES),
        .INIT_BIT    (INIT)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .s2_bit  (s2[b]),
        .deb     (deb[b])
      );
    end
  endgenerate

  // delayed debounced level for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) deb_d <= {WIDTH{INIT}};
    else          deb_d <= deb;
  end

  assign rise = deb & ~deb_d;
  assign fall = ~deb & deb_d;

  // pick which debounced transitions count as events
  always_comb begin
    edge_hit = rise | fall;
    if (EDGE_TYPE == 0)      edge_hit = rise;
    else if (EDGE_TYPE == 1) edge_hit = fall;
  end

  // RW1C clear mask from a write to the capture register
  always_comb begin
    clr = '0;
    if (wr && address == 2'd3) clr = writedata[WIDTH-1:0];
  end

  // interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 irqmask <= '0;
    else if (wr && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
  end

  // sticky capture; a new edge beats a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edgecapture <= '0;
    else          edgecapture <= (edgecapture & ~clr) | edge_hit;
  end

  // registered level interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(edgecapture & irqmask);
  end

  // zero-wait read mux, independent of chipselect
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = 32'(deb);
      2'd1: readdata = 32'(s2);
      2'd2: readdata = 32'(irqmask);
      2'd3: readdata = 32'(edgecapture);
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cq_viola_psw_in.sv
// Directed bench: falling-edge instance (u_dut) for the main checks and an
// any-edge instance (u_dut2) sharing the bus and reset for the edge/reset test.
module tb_cq_viola_psw_in;

  logic        clk, reset_n;
  logic [1:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port, in2;
  logic [31:0] readdata, readdata2;
  logic        irq, irq2;

  int n_chk  = 0;
  int n_fail = 0;

  cq_viola_psw_in #(.WIDTH(8), .SAMPLE_DIV(4), .DEB_SAMPLES(4), .EDGE_TYPE(1), .INIT_LEVEL(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq));

  cq_viola_psw_in #(.WIDTH(8), .SAMPLE_DIV(4), .DEB_SAMPLES(4), .EDGE_TYPE(2), .INIT_LEVEL(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in2),
    .readdata(readdata2), .irq(irq2));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cyc(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    int  n;
    logic found;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 8'hFF; in2 = 8'hFF;
    cyc(3);

    // 1: reset values, then idle-high pins produce nothing
    rd(0); chk("rst_deb",  readdata, 32'hFF);
    rd(1); chk("rst_s2",   readdata, 32'hFF);
    rd(2); chk("rst_mask", readdata, 32'h0);
    rd(3); chk("rst_ec",   readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    cyc(100);
    rd(3); chk("idle_ec",  readdata, 32'h0);
    rd(0); chk("idle_deb", readdata, 32'hFF);

    // 2: pin 0 falls and stays low
    in_port[0] = 1'b0;
    cyc(1); rd(1); chk("sync_1clk", readdata, 32'hFF);
    cyc(1); rd(1); chk("sync_2clk", readdata, 32'hFE);
    n = 2; found = 1'b0;
    while (!found && n < 25) begin
      cyc(1); n++;
      rd(0);
      if (readdata[0] == 1'b0) found = 1'b1;
    end
    chk("deb_lat_in_16_19", {31'b0, (found && n >= 16 && n <= 19)}, 32'h1);
    chk("deb_fall",    readdata, 32'hFE);
    rd(3); chk("ec_not_yet", readdata, 32'h0);
    cyc(1); rd(3); chk("ec_fall0", readdata, 32'h01);
    chk("irq_masked", {31'b0, irq}, 32'h0);

    // 3: 7-clk glitch on pin 3 is filtered
    in_port[3] = 1'b0;
    cyc(7);
    in_port[3] = 1'b1;
    cyc(30);
    rd(0); chk("glitch_deb", readdata, 32'hFE);
    rd(3); chk("glitch_ec",  readdata, 32'h01);

    // 4: unmask raises irq one clk later; RW1C clear drops it one clk later
    wr(2, 32'h01);
    chk("irq_pre_mask", {31'b0, irq}, 32'h0);
    cyc(1); chk("irq_masked_on", {31'b0, irq}, 32'h1);
    wr(3, 32'h01);
    rd(3); chk("ec_cleared", readdata, 32'h0);
    chk("irq_hold_1clk", {31'b0, irq}, 32'h1);
    cyc(1); chk("irq_off", {31'b0, irq}, 32'h0);

    // 5: rising edge ignored, then clear collides with the next fall
    in_port[0] = 1'b1;
    cyc(30);
    rd(0); chk("rise_deb", readdata, 32'hFF);
    rd(3); chk("rise_not_captured", readdata, 32'h0);
    in_port[0] = 1'b0;
    n = 0; found = 1'b0;
    while (!found && n < 25) begin
      cyc(1); n++;
      rd(0);
      if (readdata[0] == 1'b0) begin
        found = 1'b1;
        wr(3, 32'h01);
      end
    end
    chk("fall2_seen", {31'b0, found}, 32'h1);
    rd(3); chk("set_wins", readdata, 32'h01);
    cyc(1); rd(3); chk("set_sticky", readdata, 32'h01);
    chk("irq_after_set", {31'b0, irq}, 32'h1);

    // 6: any-edge instance, two captures, then mid-sequence reset
    in_port = 8'hFF;
    in2[7] = 1'b0;
    cyc(40);
    rd(0); chk("e2_deb_low", readdata2, 32'h7F);
    rd(3); chk("e2_ec_fall", readdata2, 32'h80);
    wr(3, 32'h80);
    rd(3); chk("e2_ec_clr", readdata2, 32'h0);
    in2[7] = 1'b1;
    cyc(40);
    rd(0); chk("e2_deb_high", readdata2, 32'hFF);
    rd(3); chk("e2_ec_rise", readdata2, 32'h80);
    wr(2, 32'hFF);
    cyc(1); chk("e2_irq_on", {31'b0, irq2}, 32'h1);
    in2[7] = 1'b0;
    cyc(10);
    reset_n = 1'b0;
    #1;
    rd(0); chk("mrst_deb",  readdata2, 32'hFF);
    rd(1); chk("mrst_s2",   readdata2, 32'hFF);
    rd(2); chk("mrst_mask", readdata2, 32'h0);
    rd(3); chk("mrst_ec",   readdata2, 32'h0);
    chk("mrst_ec1", readdata, 32'h0);
    chk("mrst_irq2", {31'b0, irq2}, 32'h0);
    chk("mrst_irq1", {31'b0, irq}, 32'h0);
    in2 = 8'hFF;
    cyc(3);
    reset_n = 1'b1;
    cyc(40);
    rd(3); chk("post_rst_ec2", readdata2, 32'h0);
    chk("post_rst_ec1", readdata, 32'h0);
    rd(0); chk("post_rst_deb2", readdata2, 32'hFF);
    chk("post_rst_deb1", readdata, 32'hFF);
    chk("post_rst_irq", {30'b0, irq, irq2}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
